mem_ctrl: RTL and testbench

Parametrised single-port synchronous memory with a valid/ready request handshake, per-byte write enables, programmable wait states, and out-of-range address detection. After reset it clears its own contents. It is the next-generation storage block behind the bus-side request masters, and it keeps the existing frontdoor protocol: `valid_i`, `wrdata_i`, `addre_i`, `write_i` in; `ready_o`, `read_o` out. Its storage array stays reachable by hierarchical path for backdoor load and dump.

---
 rtl/mem_ctrl_pkg.sv | 18 +
 rtl/mem_ctrl_if.sv | 26 ++
 rtl/mem_array.sv | 46 ++++
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the mem_ctrl storage block: FSM state encoding,
// wait-counter width and byte-lane count.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int WCNT_W = 4;

  function automatic int lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Frontdoor request/response bundle for mem_ctrl; the master holds the request
// fields from valid_i until it sees the ready_o pulse.
interface mem_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int ADDRE = 8
);
  logic                                     valid_i;
  logic                                     wrdata_i;
  logic [ADDRE-1:0]                         addre_i;
  logic [WIDTH-1:0]                         write_i;
  logic [mem_ctrl_pkg::lanes(WIDTH)-1:0]    be_i;
  logic                                     ready_o;
  logic [WIDTH-1:0]                         read_o;
  logic                                     err_o;
  logic                                     init_done_o;

  modport master (
    output valid_i, wrdata_i, addre_i, write_i, be_i,
    input  ready_o, read_o, err_o, init_done_o
  );

  modport slave (
    input  valid_i, wrdata_i, addre_i, write_i, be_i,
    output ready_o, read_o, err_o, init_done_o
  );
endinterface

// File: rtl/mem_array.sv
// Storage only: byte-enabled synchronous write, combinational read; no reset.
// MEM_PARITY_EN adds mem_par, one even-parity bit per byte written with its byte.
module mem_array
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic [lanes(WIDTH)-1:0] i_be,
  input  logic [AW-1:0]           i_raddr,
`ifdef MEM_PARITY_EN
  output logic [lanes(WIDTH)-1:0] o_rpar,
`endif
  output logic [WIDTH-1:0]        o_rdata
);
  localparam int NB = lanes(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef MEM_PARITY_EN
  logic [NB-1:0] mem_par [DEPTH];
`endif

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < NB; i++) begin
        if (i_be[i]) begin
          mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
          mem_par[i_waddr][i] <= ^i_wdata[8*i +: 8];
`endif
        end
      end
    end
  end

  assign o_rdata = mem[i_raddr];
`ifdef MEM_PARITY_EN
  assign o_rpar = mem_par[i_raddr];
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Single-port memory: clears itself after reset, then serves one request at a time; ready_o pulses
// WAIT_CYC+1 cycles after accept, master holds valid_i until then. MEM_PARITY_EN adds per-byte parity checks.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 256,
  parameter int ADDRE    = 8,
  parameter int WAIT_CYC = 1
) (
  input logic       clk_i,
  input logic       rst_i,
  mem_ctrl_if.slave bus
);
  localparam int            NB   = lanes(WIDTH);
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t            r_state, w_nxt_state;
  logic [AW-1:0]     r_init_cnt;
  logic              r_init_done;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_wr;
  logic [ADDRE-1:0]  r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [NB-1:0]     r_be;
  logic [WIDTH-1:0]  r_read;
  logic              r_err;

  logic              w_accept, w_go_resp;
  logic              w_req_wr, w_in_range, w_err;
  logic [ADDRE-1:0]  w_req_addr;
  logic [WIDTH-1:0]  w_req_wdata;
  logic [NB-1:0]     w_req_be;
  logic [AW-1:0]     w_idx;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [WIDTH-1:0]  w_mem_wdata;
  logic [NB-1:0]     w_mem_be;
  logic [WIDTH-1:0]  w_rdata;
  logic              w_par_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= INIT;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_accept    = 1'b0;
    w_go_resp   = 1'b0;
    case (r_state)
      INIT: if (r_init_cnt == LAST) w_nxt_state = IDLE;
      IDLE: begin
        if (bus.valid_i) begin
          w_accept = 1'b1;
          if (WAIT_CYC == 0) begin
            w_go_resp   = 1'b1;
            w_nxt_state = RESP;
          end else begin
            w_nxt_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_wcnt == '0) begin
          w_go_resp   = 1'b1;
          w_nxt_state = RESP;
        end
      end
      RESP:    w_nxt_state = IDLE;
      default: w_nxt_state = INIT;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live request is used directly.
  assign w_req_wr    = (r_state == IDLE) ? bus.wrdata_i : r_wr;
  assign w_req_addr  = (r_state == IDLE) ? bus.addre_i  : r_addr;
  assign w_req_wdata = (r_state == IDLE) ? bus.write_i  : r_wdata;
  assign w_req_be    = (r_state == IDLE) ? bus.be_i     : r_be;
  assign w_idx       = w_req_addr[AW-1:0];
  assign w_in_range  = 32'(w_req_addr) < DEPTH;

  always_comb begin
    w_mem_we    = w_go_resp & w_req_wr & w_in_range;
    w_mem_addr  = w_idx;
    w_mem_wdata = w_req_wdata;
    w_mem_be    = w_req_be;
    if (r_state == INIT) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_init_cnt;
      w_mem_wdata = '0;
      w_mem_be    = '1;
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] w_rpar, w_calc_par;
  always_comb begin
    w_calc_par = '0;
    for (int i = 0; i < NB; i++) w_calc_par[i] = ^w_rdata[8*i +: 8];
  end
  assign w_par_err = |(w_rpar ^ w_calc_par);
`else
  assign w_par_err = 1'b0;
`endif

  assign w_err = !w_in_range | (!w_req_wr & w_par_err);

  mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_array (
    .i_clk   (clk_i),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .i_be    (w_mem_be),
    .i_raddr (w_idx),
`ifdef MEM_PARITY_EN
    .o_rpar  (w_rpar),
`endif
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_wcnt      <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_read      <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == INIT && r_init_cnt != LAST) r_init_cnt <= r_init_cnt + 1'b1;
      if (r_state == INIT && r_init_cnt == LAST) r_init_done <= 1'b1;
      if (w_accept) begin
        r_wr    <= bus.wrdata_i;
        r_addr  <= bus.addre_i;
        r_wdata <= bus.write_i;
        r_be    <= bus.be_i;
        r_wcnt  <= WCNT_W'(WAIT_CYC - 1);
      end else if (r_state == WAIT && r_wcnt != '0) begin
        r_wcnt <= r_wcnt - 1'b1;
      end
      if (w_go_resp) begin
        r_err <= w_err;
        if (!w_req_wr) r_read <= w_in_range ? w_rdata : '0;
      end
    end
  end

  assign bus.ready_o     = (r_state == RESP);
  assign bus.err_o       = (r_state == RESP) & r_err;
  assign bus.read_o      = r_read;
  assign bus.init_done_o = r_init_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: dut (DEPTH 256, one wait state) and dut_b (DEPTH 200, zero wait states).
// Expected responses are queued when a request is driven and checked when ready_o pulses.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_if #(.WIDTH(32), .ADDRE(8)) bus_a ();
  mem_ctrl_if #(.WIDTH(32), .ADDRE(8)) bus_b ();

  mem_ctrl #(.WIDTH(32), .DEPTH(256), .ADDRE(8), .WAIT_CYC(1)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_a)
  );

  mem_ctrl #(.WIDTH(32), .DEPTH(200), .ADDRE(8), .WAIT_CYC(0)) dut_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rd;
  } vec_t;

  exp_t        sb [$];
  logic [31:0] lr [2];
  logic [31:0] img [200];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within budget", nm);
  endtask

  task automatic drive(input bit b, input logic v, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (!b) begin
      bus_a.valid_i = v; bus_a.wrdata_i = wr; bus_a.addre_i = a; bus_a.write_i = d; bus_a.be_i = be;
    end else begin
      bus_b.valid_i = v; bus_b.wrdata_i = wr; bus_b.addre_i = a; bus_b.write_i = d; bus_b.be_i = be;
    end
  endtask

  task automatic issue(input bit b, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] xd, input logic xe, input int xc);
    exp_t x;
    drive(b, 1'b1, wr, a, d, be);
    x.d = xd; x.e = xe; x.cyc = xc;
    sb.push_back(x);
  endtask

  task automatic wait_rsp(input bit b);
    logic        r, e;
    logic [31:0] d;
    exp_t        x;
    r = 1'b0; e = 1'b0; d = '0;
    for (int t = 0; t < 20 && !r; t++) begin
      @(negedge clk);
      r = b ? bus_b.ready_o : bus_a.ready_o;
      e = b ? bus_b.err_o   : bus_a.err_o;
      d = b ? bus_b.read_o  : bus_a.read_o;
    end
    if (!r) fail("rsp_timeout");
    else if (sb.size() == 0) fail("rsp_unexpected");
    else begin
      x = sb.pop_front();
      chk("rsp_cycle", 64'(cyc), 64'(x.cyc));
      chk("read_o", 64'(d), 64'(x.d));
      chk("err_o", 64'(e), 64'(x.e));
    end
  endtask

  // Read responses set the expected read_o; write responses must leave it holding.
  task automatic single(input bit b, input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] rd, input logic e);
    logic [31:0] x;
    x = wr ? lr[b] : rd;
    lr[b] = x;
    @(negedge clk);
    issue(b, wr, a, d, be, x, e, cyc + 1 + (b ? 0 : 1));
    wait_rsp(b);
    drive(b, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
  endtask

  task automatic wait_init(output int na, output int nb, output bit saw);
    na = 0; nb = 0; saw = 1'b0;
    for (int n = 1; n <= 300 && na == 0; n++) begin
      @(posedge clk);
      #1;
      bus_a.valid_i = (n < 100) && (n % 2 == 0);
      if (bus_a.ready_o) saw = 1'b1;
      if (nb == 0 && bus_b.init_done_o) nb = n;
      if (bus_a.init_done_o) na = n;
    end
    bus_a.valid_i = 1'b0;
  endtask

  initial begin
    vec_t vt [12];
    int   na, nb, nz;
    bit   saw;

    vt[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 8'h20, 32'h11223344, 4'hF, 32'h0};
    vt[3]  = '{1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 32'h0};
    vt[4]  = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h11BB33DD};
    vt[5]  = '{1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, 32'h0};
    vt[6]  = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h11BB33DD};
    vt[7]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0};
    vt[8]  = '{1'b1, 8'hFF, 32'h12345678, 4'hF, 32'h0};
    vt[9]  = '{1'b0, 8'hFF, 32'h0,        4'h0, 32'h12345678};
    vt[10] = '{1'b1, 8'h01, 32'hCAFEF00D, 4'h8, 32'h0};
    vt[11] = '{1'b0, 8'h01, 32'h0,        4'h0, 32'hCA000000};

    lr[0] = '0;
    lr[1] = '0;
    drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 256; i++) dut.u_array.mem[i] = 32'hA5A50000 | 32'(i);
    #2;
    chk("reset_outputs_a", 64'({bus_a.ready_o, bus_a.err_o, bus_a.init_done_o, bus_a.read_o}), 64'h0);
    chk("reset_outputs_b", 64'({bus_b.ready_o, bus_b.err_o, bus_b.init_done_o, bus_b.read_o}), 64'h0);

    @(negedge clk) rst_n = 1'b1;
    wait_init(na, nb, saw);
    chk("init_done_edge_a", 64'(na), 64'd256);
    chk("init_done_edge_b", 64'(nb), 64'd200);
    chk("ready_during_init", 64'(saw), 64'h0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (dut.u_array.mem[i] !== 32'h0) nz++;
    chk("clear_dump_nonzero", 64'(nz), 64'h0);

    for (int i = 0; i < 12; i++)
      single(1'b0, vt[i].wr, vt[i].a, vt[i].d, vt[i].be, vt[i].rd, 1'b0);

    for (int i = 0; i < 200; i++) img[i] = 32'h0;
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    img[199] = 32'h5A5A1234;
    for (int i = 0; i < 200; i++) dut_b.u_array.mem[i] = img[i];

    // Four reads with valid_i held high: one response every two cycles.
    @(negedge clk);
    issue(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, img[0], 1'b0, cyc + 1);
    for (int k = 1; k < 4; k++) begin
      wait_rsp(1'b1);
      issue(1'b1, 1'b0, 8'(k), 32'h0, 4'h0, img[k], 1'b0, cyc + 2);
    end
    wait_rsp(1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    lr[1] = img[3];

    single(1'b1, 1'b1, 8'd220, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    single(1'b1, 1'b0, 8'd220, 32'h0, 4'h0, 32'h0, 1'b1);
    single(1'b1, 1'b0, 8'd199, 32'h0, 4'h0, 32'h5A5A1234, 1'b0);
    single(1'b1, 1'b0, 8'd200, 32'h0, 4'h0, 32'h0, 1'b1);
    single(1'b1, 1'b1, 8'd2, 32'h77777777, 4'h0, 32'h0, 1'b0);
    single(1'b1, 1'b1, 8'd50, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    img[50] = 32'h0BADF00D;
    single(1'b1, 1'b0, 8'd50, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
    nz = 0;
    for (int i = 0; i < 200; i++) if (dut_b.u_array.mem[i] !== img[i]) nz++;
    chk("b_dump_diffs", 64'(nz), 64'h0);

`ifdef MEM_PARITY_EN
    dut.u_array.mem_par[5][0] = ~dut.u_array.mem_par[5][0];
    single(1'b0, 1'b0, 8'd5, 32'h0, 4'h0, 32'h0, 1'b1);
`endif

    // Reset while a write waits for its commit edge, then reset again part-way through the sweep.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h30, 32'h13572468, 4'hF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreq_reset_outputs", 64'({bus_a.ready_o, bus_a.err_o, bus_a.init_done_o, bus_a.read_o}), 64'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    lr[0] = '0;
    lr[1] = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    wait_init(na, nb, saw);
    chk("reinit_edge_a", 64'(na), 64'd256);
    chk("reinit_edge_b", 64'(nb), 64'd200);
    single(1'b0, 1'b0, 8'h30, 32'h0, 4'h0, 32'h0, 1'b0);
    single(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0);
    single(1'b1, 1'b0, 8'd50, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
